// File: rtl/drdy_pkg.sv
// drdy_pkg -- shared constants for the DRDY timestamp capture block.
// Holds the capture FSM state encoding and the Lost_Cnt saturation limit.
package drdy_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOST = 2'd2;

  localparam logic [7:0] LOST_CNT_MAX = 8'd255;

  // Increment that sticks at the saturation value instead of wrapping.
  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == LOST_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/drdy_us_tick.sv
// drdy_us_tick -- microsecond prescaler and free-running timestamp counter.
// tick is high for one CLK cycle per microsecond; Ts_Cnt advances on each tick
// and wraps naturally at 2^TS_W.
module drdy_us_tick
  import drdy_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TS_W         = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic            tick,
  output logic [TS_W-1:0] Ts_Cnt
);

  localparam int PRE_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_MHZ - 1);

  logic [PRE_W-1:0] preCnt_q, preCnt_d;
  logic [TS_W-1:0]  tsCnt_q, tsCnt_d;

  assign tick   = (preCnt_q == PRE_LAST);
  assign Ts_Cnt = tsCnt_q;

  // Next-state for the prescaler (0..CLK_FREQ_MHZ-1) and the timestamp.
  always_comb begin
    preCnt_d = tick ? '0 : preCnt_q + PRE_W'(1);
    tsCnt_d  = tick ? tsCnt_q + TS_W'(1) : tsCnt_q;
  end

  // Counter registers, cleared only by reset so time keeps running through Clr.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      preCnt_q <= '0;
      tsCnt_q  <= '0;
    end else begin
      preCnt_q <= preCnt_d;
      tsCnt_q  <= tsCnt_d;
    end
  end

endmodule

// File: rtl/drdy_timestamp_capture.sv
// drdy_timestamp_capture -- timestamps sensor data-ready edges into a small
// FIFO, watches for missing edges (IDLE/RUN/LOST watchdog FSM) and optionally
// measures the edge-to-edge period.
// Optional feature macro: DRDY_PERIOD_MEAS_EN enables Period_Us/Period_Vld;
// without it both outputs are tied to 0 and no previous-timestamp register exists.
module drdy_timestamp_capture
  import drdy_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TS_W         = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_US   = 10000
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            Edge_Pulse,
  input  logic            Rd_En,
  input  logic            Clr,
  output logic [TS_W-1:0] Rd_Data,
  output logic            Rd_Valid,
  output logic            Fifo_Empty,
  output logic            Fifo_Full,
  output logic            Overflow,
  output logic            Lost_Sig,
  output logic [7:0]      Lost_Cnt,
  output logic [TS_W-1:0] Period_Us,
  output logic            Period_Vld
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WD_W = $clog2(TIMEOUT_US + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_US);

  logic            tick;
  logic [TS_W-1:0] tsNow;

  drdy_us_tick #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
    .TS_W        (TS_W)
  ) u_tick (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .tick  (tick),
    .Ts_Cnt(tsNow)
  );

  // Clr wins over a same-cycle edge or pop, so both are masked here.
  logic edgeEv, rdReq, doRead, doWrite, fifoEmpty, fifoFull;

  logic [TS_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [TS_W-1:0] rdData_q, rdData_d;
  logic            rdValid_q, rdValid_d;
  logic            overflow_q, overflow_d;

  logic [1:0]      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      lostCnt_q, lostCnt_d;
  logic            lostSig_q, lostSig_d;

  assign edgeEv    = Edge_Pulse & ~Clr;
  assign rdReq     = Rd_En & ~Clr;
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doRead    = rdReq & ~fifoEmpty;
  assign doWrite   = edgeEv & (~fifoFull | doRead);

  // FIFO pointer, read-data and overflow next-state; a full FIFO still accepts a write when a pop frees a slot.
  always_comb begin
    wrPtr_d    = Clr ? '0 : wrPtr_q + (AW+1)'(doWrite);
    rdPtr_d    = Clr ? '0 : rdPtr_q + (AW+1)'(doRead);
    rdData_d   = doRead ? mem_q[rdPtr_q[AW-1:0]] : rdData_q;
    rdValid_d  = doRead;
    overflow_d = Clr ? 1'b0 : (overflow_q | (edgeEv & fifoFull & ~doRead));
  end

  // Timestamp storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (doWrite) mem_q[wrPtr_q[AW-1:0]] <= tsNow;
  end

  // Watchdog FSM: any edge restarts the watchdog, which only counts microseconds while in RUN.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    lostCnt_d = lostCnt_q;
    if (Clr) begin
      state_d   = ST_IDLE;
      wd_d      = '0;
      lostCnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_d = '0;
          if (edgeEv) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (edgeEv) begin
            wd_d = '0;
          end else if (wd_q >= WD_LIMIT) begin
            state_d   = ST_LOST;
            wd_d      = '0;
            lostCnt_d = satInc(lostCnt_q);
          end else if (tick) begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        ST_LOST: begin
          wd_d = '0;
          if (edgeEv) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          wd_d    = '0;
        end
      endcase
    end
    lostSig_d = (state_d == ST_LOST);
  end

  // Main state registers under asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      rdData_q   <= '0;
      rdValid_q  <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      wd_q       <= '0;
      lostCnt_q  <= '0;
      lostSig_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      rdData_q   <= rdData_d;
      rdValid_q  <= rdValid_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      wd_q       <= wd_d;
      lostCnt_q  <= lostCnt_d;
      lostSig_q  <= lostSig_d;
    end
  end

  assign Rd_Data    = rdData_q;
  assign Rd_Valid   = rdValid_q;
  assign Fifo_Empty = fifoEmpty;
  assign Fifo_Full  = fifoFull;
  assign Overflow   = overflow_q;
  assign Lost_Sig   = lostSig_q;
  assign Lost_Cnt   = lostCnt_q;

`ifdef DRDY_PERIOD_MEAS_EN
  logic [TS_W-1:0] tsPrev_q, tsPrev_d, period_q, period_d;
  logic            periodVld_q, periodVld_d;

  // Period is only meaningful between two edges seen back to back in RUN.
  always_comb begin
    tsPrev_d    = edgeEv ? tsNow : tsPrev_q;
    periodVld_d = edgeEv && (state_q == ST_RUN);
    period_d    = periodVld_d ? (tsNow - tsPrev_q) : period_q;
  end

  // Period measurement registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tsPrev_q    <= '0;
      period_q    <= '0;
      periodVld_q <= 1'b0;
    end else begin
      tsPrev_q    <= tsPrev_d;
      period_q    <= period_d;
      periodVld_q <= periodVld_d;
    end
  end

  assign Period_Us  = period_q;
  assign Period_Vld = periodVld_q;
`else
  assign Period_Us  = '0;
  assign Period_Vld = 1'b0;
`endif

endmodule

// File: tb/tb_drdy_timestamp_capture.sv
// tb_drdy_timestamp_capture -- directed self-checking bench for
// drdy_timestamp_capture (CLK_FREQ_MHZ=50, TIMEOUT_US=100, FIFO_DEPTH=4).
// Period expectations follow DRDY_PERIOD_MEAS_EN in the same way as the RTL build.
module tb_drdy_timestamp_capture;

  localparam int CLK_FREQ_MHZ = 50;
  localparam int TS_W         = 32;
  localparam int FIFO_DEPTH   = 4;
  localparam int TIMEOUT_US   = 100;

`ifdef DRDY_PERIOD_MEAS_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RSTn;
  logic            Edge_Pulse, Rd_En, Clr;
  logic [TS_W-1:0] Rd_Data, Period_Us;
  logic            Rd_Valid, Fifo_Empty, Fifo_Full, Overflow, Lost_Sig, Period_Vld;
  logic [7:0]      Lost_Cnt;

  int testCnt = 0;
  int failCnt = 0;
  logic [31:0] pops [8];
  logic        popValid;

  drdy_timestamp_capture #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
    .TS_W        (TS_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_US  (TIMEOUT_US)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Edge_Pulse(Edge_Pulse),
    .Rd_En     (Rd_En),
    .Clr       (Clr),
    .Rd_Data   (Rd_Data),
    .Rd_Valid  (Rd_Valid),
    .Fifo_Empty(Fifo_Empty),
    .Fifo_Full (Fifo_Full),
    .Overflow  (Overflow),
    .Lost_Sig  (Lost_Sig),
    .Lost_Cnt  (Lost_Cnt),
    .Period_Us (Period_Us),
    .Period_Vld(Period_Vld)
  );

  always #5 CLK = ~CLK;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive the inputs for exactly one clock cycle, starting at a falling edge.
  task automatic applyStimulus(input logic e, input logic r, input logic c);
    Edge_Pulse = e;
    Rd_En      = r;
    Clr        = c;
    @(negedge CLK);
    Edge_Pulse = 1'b0;
    Rd_En      = 1'b0;
    Clr        = 1'b0;
  endtask

  task automatic popOne(output logic [31:0] data, output logic valid);
    applyStimulus(1'b0, 1'b1, 1'b0);
    data  = Rd_Data;
    valid = Rd_Valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTn = 1'b0; Edge_Pulse = 1'b0; Rd_En = 1'b0; Clr = 1'b0;
    waitCycles(3);

    // Reset values
    checkOutput("rst_empty",   32'(Fifo_Empty), 32'd1);
    checkOutput("rst_full",    32'(Fifo_Full),  32'd0);
    checkOutput("rst_ovf",     32'(Overflow),   32'd0);
    checkOutput("rst_lost",    32'(Lost_Sig),   32'd0);
    checkOutput("rst_rdvalid", 32'(Rd_Valid),   32'd0);
    checkOutput("rst_pvld",    32'(Period_Vld), 32'd0);
    checkOutput("rst_lostcnt", 32'(Lost_Cnt),   32'd0);
    checkOutput("rst_rddata",  Rd_Data,         32'd0);
    checkOutput("rst_period",  Period_Us,       32'd0);
    RSTn = 1'b1;
    waitCycles(2);

    // Edges 20 us apart, then three pops
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_first_pvld", 32'(Period_Vld), 32'd0);
    checkOutput("t1_not_empty",  32'(Fifo_Empty), 32'd0);
    for (int i = 0; i < 2; i++) begin
      waitCycles(999);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_pvld",   32'(Period_Vld), 32'(PEN));
      checkOutput("t1_period", Period_Us, PEN ? 32'd20 : 32'd0);
    end
    waitCycles(1);
    checkOutput("t1_pvld_drop", 32'(Period_Vld), 32'd0);
    checkOutput("t1_lost",      32'(Lost_Sig),   32'd0);
    for (int i = 0; i < 3; i++) begin
      popOne(pops[i], popValid);
      checkOutput("t1_pop_valid", 32'(popValid), 32'd1);
    end
    waitCycles(1);
    checkOutput("t1_valid_drop", 32'(Rd_Valid), 32'd0);
    checkOutput("t1_step1", pops[1] - pops[0], 32'd20);
    checkOutput("t1_step2", pops[2] - pops[1], 32'd20);
    checkOutput("t1_empty", 32'(Fifo_Empty), 32'd1);

    // Five edges with no reads: fourth fills, fifth overflows
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 2) checkOutput("t2_full_at3", 32'(Fifo_Full), 32'd0);
      if (i == 3) begin
        checkOutput("t2_full_at4", 32'(Fifo_Full), 32'd1);
        checkOutput("t2_ovf_at4",  32'(Overflow),  32'd0);
      end
      waitCycles(49);
    end
    checkOutput("t2_ovf", 32'(Overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      popOne(pops[i], popValid);
      checkOutput("t2_pop_valid", 32'(popValid), 32'd1);
    end
    for (int i = 1; i < 4; i++) checkOutput("t2_step", pops[i] - pops[i-1], 32'd1);
    checkOutput("t2_empty",      32'(Fifo_Empty), 32'd1);
    checkOutput("t2_ovf_sticky", 32'(Overflow),   32'd1);
    popOne(pops[4], popValid);
    checkOutput("t2_empty_pop_valid", 32'(popValid),   32'd0);
    checkOutput("t2_empty_pop_empty", 32'(Fifo_Empty), 32'd1);

    // Write and read together while full
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2b_ovf_clr", 32'(Overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(49);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    pops[0] = Rd_Data;
    checkOutput("t2b_rw_valid", 32'(Rd_Valid),  32'd1);
    checkOutput("t2b_rw_full",  32'(Fifo_Full), 32'd1);
    checkOutput("t2b_rw_ovf",   32'(Overflow),  32'd0);
    for (int i = 1; i < 5; i++) popOne(pops[i], popValid);
    for (int i = 1; i < 5; i++) checkOutput("t2b_step", pops[i] - pops[i-1], 32'd1);
    checkOutput("t2b_empty", 32'(Fifo_Empty), 32'd1);

    // Edge then 100 us of silence goes LOST; next edge recovers without a period
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(4899);
    checkOutput("t3_lost_early", 32'(Lost_Sig), 32'd0);
    waitCycles(200);
    checkOutput("t3_lost",    32'(Lost_Sig), 32'd1);
    checkOutput("t3_lostcnt", 32'(Lost_Cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t3_recover",  32'(Lost_Sig),   32'd0);
    checkOutput("t3_no_pvld",  32'(Period_Vld), 32'd0);

    // Clr together with Edge_Pulse and Rd_En
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_empty",   32'(Fifo_Empty), 32'd1);
    checkOutput("t5_rdvalid", 32'(Rd_Valid),   32'd0);
    checkOutput("t5_lostcnt", 32'(Lost_Cnt),   32'd0);
    checkOutput("t5_lost",    32'(Lost_Sig),   32'd0);
    waitCycles(20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_idle_no_pvld", 32'(Period_Vld), 32'd0);
    popOne(pops[0], popValid);
    checkOutput("t5_pop_valid", 32'(popValid), 32'd1);

    // Timestamp wrap: preset near 2^32-5, edges 10 us apart
    applyStimulus(1'b0, 1'b0, 1'b1);
    force dut.u_tick.tsCnt_q = 32'hFFFF_FFFB;
    @(negedge CLK);
    release dut.u_tick.tsCnt_q;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(499);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_pvld",   32'(Period_Vld), 32'(PEN));
    checkOutput("t4_period", Period_Us, PEN ? 32'd10 : 32'd0);
    popOne(pops[0], popValid);
    popOne(pops[1], popValid);
    checkOutput("t4_first_high", 32'(pops[0] >= 32'hFFFF_FFF0), 32'd1);
    checkOutput("t4_wrapped",    32'(pops[1] < 32'd10),         32'd1);
    checkOutput("t4_step",       pops[1] - pops[0],             32'd10);

    // Reset mid-operation discards buffered entries
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2 RSTn = 1'b0;
    #1;
    checkOutput("t6_rst_empty",  32'(Fifo_Empty), 32'd1);
    checkOutput("t6_rst_rddata", Rd_Data,         32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    popOne(pops[0], popValid);
    checkOutput("t6_no_valid", 32'(popValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
